dmem_mmio: RTL and testbench



---
 rtl/dmem_mmio.sv | 155 +++++++++++++++
 tb/tb_dmem_mmio.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory responder for the pipelined core's Memory stage.
// Word-addressed data RAM with combinational read, plus a 16-byte MMIO
// window holding a console TX FIFO, a free-running cycle counter and an
// exit register. Writes to addresses outside both regions flag bad_access.
module dmem_mmio #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] exit_code,
  output logic        bad_access
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [PTR_W:0] FIFO_CAP = FIFO_DEPTH[PTR_W:0];

  localparam logic [1:0] REG_CONSOLE = 2'd0;
  localparam logic [1:0] REG_CYCLE   = 2'd1;
  localparam logic [1:0] REG_EXIT    = 2'd2;

  // Storage
  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  fifoMem [FIFO_DEPTH];

  // Address decode (byte offset a[1:0] never participates)
  logic             isRam;
  logic             isMmio;
  logic [1:0]       regSel;
  logic [IDX_W-1:0] ramIdx;

  // Console FIFO state
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W:0]   fifoCount;
  logic             overflow;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             pop;
  logic             pushReq;
  logic             pushOk;

  logic [31:0] cycleCount;

  // RAM is checked first so a misplaced MMIO_BASE can never shadow RAM.
  assign isRam  = ({1'b0, a} < RAM_BYTES);
  assign isMmio = !isRam && (a[31:4] == MMIO_BASE[31:4]);
  assign regSel = a[3:2];
  assign ramIdx = a[IDX_W+1:2];

  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == FIFO_CAP);
  assign pop       = !fifoEmpty && tx_ready;
  assign pushReq   = we && isMmio && (regSel == REG_CONSOLE);
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign pushOk    = pushReq && (!fifoFull || pop);

  assign tx_valid = !fifoEmpty;
  assign tx_data  = fifoMem[headPtr];

  // RAM write port; contents survive reset because they are preloaded.
  always_ff @(posedge clk) begin
    if (!reset && we && isRam) begin
      mem[ramIdx] <= wd;
    end
  end

  // FIFO data storage; the slot at tailPtr is free or being popped this cycle.
  always_ff @(posedge clk) begin
    if (!reset && pushOk) begin
      fifoMem[tailPtr] <= wd[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pop) begin
        headPtr <= headPtr + 1'b1;
      end
      if (pushOk) begin
        tailPtr <= tailPtr + 1'b1;
      end
      if (pushReq && !pushOk) begin
        overflow <= 1'b1;
      end
      case ({pushOk, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Free-running cycle counter, zero in the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycleCount <= '0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  // Exit register latches only the first write after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      exit_code <= '0;
    end else if (we && isMmio && (regSel == REG_EXIT) && !done) begin
      done      <= 1'b1;
      exit_code <= wd;
    end
  end

  // Unmapped writes are sticky errors; unmapped reads may be speculative.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_access <= 1'b0;
    end else if (we && !isRam && !isMmio) begin
      bad_access <= 1'b1;
    end
  end

  // Read data mux; every MMIO read reflects state before the coming edge.
  always_comb begin
    rd = '0;
    if (isRam) begin
      rd = mem[ramIdx];
    end else if (isMmio) begin
      case (regSel)
        REG_CONSOLE: rd = {29'b0, overflow, fifoEmpty, fifoFull};
        REG_CYCLE:   rd = cycleCount;
        REG_EXIT:    rd = {31'b0, done};
        default:     rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, console FIFO, cycle
// counter, exit register, reserved and unmapped accesses, reset.
module tb_dmem_mmio;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] CONS  = BASE;
  localparam logic [31:0] CYC   = BASE + 32'd4;
  localparam logic [31:0] EXITA = BASE + 32'd8;
  localparam logic [31:0] RSV   = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic [31:0] exit_code;
  logic        bad_access;

  int tests = 0;
  int fails = 0;
  int tbCycle = 0;

  dmem_mmio #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .a         (a),
    .wd        (wd),
    .rd        (rd),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (done),
    .exit_code (exit_code),
    .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] ok   %s = %h", tag, obs);
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    tbCycle++;
  endtask

  task automatic drive(input logic w, input logic [31:0] addr, input logic [31:0] data);
    we = w;
    a  = addr;
    wd = data;
    #1;
  endtask

  // One-cycle reset; afterwards the counter should read 0.
  task automatic doReset();
    reset    = 1'b1;
    we       = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    tbCycle = 0;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    we       = 1'b0;
    a        = '0;
    wd       = '0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_bad_access", {31'b0, bad_access}, 32'd0);

    // Cycle counter from reset release
    reset   = 1'b0;
    tbCycle = 0;
    drive(1'b0, CYC, 32'd0);
    check("cycle_at_0", rd, 32'd0);
    drive(1'b0, CONS, 32'd0);
    check("status_after_reset", rd, 32'h2);
    repeat (5) step();
    drive(1'b0, CYC, 32'd0);
    check("cycle_at_5", rd, 32'd5);

    // RAM write/read timing
    drive(1'b1, 32'h40, 32'h1111_1111);
    step();
    drive(1'b1, 32'h40, 32'hDEAD_BEEF);
    check("ram_same_cycle_old", rd, 32'h1111_1111);
    step();
    drive(1'b0, 32'h40, 32'd0);
    check("ram_next_cycle_new", rd, 32'hDEAD_BEEF);
    drive(1'b0, 32'h42, 32'd0);
    check("ram_byte_offset_ignored", rd, 32'hDEAD_BEEF);
    drive(1'b1, 32'h44, 32'h0BAD_F00D);
    step();
    drive(1'b0, 32'h40, 32'd0);
    check("ram_neighbour_untouched", rd, 32'hDEAD_BEEF);
    drive(1'b1, 32'hFFC, 32'hA5A5_0001);
    step();
    drive(1'b0, 32'hFFC, 32'd0);
    check("ram_top_word", rd, 32'hA5A5_0001);
    check("ram_no_bad_access", {31'b0, bad_access}, 32'd0);

    // Console ordering with backpressure
    tx_ready = 1'b0;
    drive(1'b1, CONS, 32'h48);
    check("tx_not_valid_before_push", {31'b0, tx_valid}, 32'd0);
    step();
    drive(1'b1, CONS, 32'h69);
    check("tx_valid_after_push", {31'b0, tx_valid}, 32'd1);
    check("tx_head_H", {24'b0, tx_data}, 32'h48);
    step();
    drive(1'b0, CONS, 32'd0);
    check("tx_head_held", {24'b0, tx_data}, 32'h48);
    tx_ready = 1'b1;
    step();
    check("tx_head_i", {24'b0, tx_data}, 32'h69);
    check("tx_valid_second", {31'b0, tx_valid}, 32'd1);
    step();
    tx_ready = 1'b0;
    drive(1'b0, CONS, 32'd0);
    check("tx_drained", {31'b0, tx_valid}, 32'd0);
    check("status_empty", rd, 32'h2);

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CONS, 32'h30 + 32'(i));
      step();
    end
    drive(1'b0, CONS, 32'd0);
    check("status_full", rd, 32'h1);
    drive(1'b1, CONS, 32'h38);
    step();
    drive(1'b0, CONS, 32'd0);
    check("status_full_overflow", rd, 32'h5);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", {24'b0, tx_data}, 32'h30 + 32'(i));
      step();
    end
    tx_ready = 1'b0;
    drive(1'b0, CONS, 32'd0);
    check("ninth_byte_lost", {31'b0, tx_valid}, 32'd0);
    check("status_overflow_sticky", rd, 32'h6);

    // Full FIFO accepts a push when the head pops in the same cycle
    doReset();
    drive(1'b0, CONS, 32'd0);
    check("status_overflow_cleared", rd, 32'h2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CONS, 32'h30 + 32'(i));
      step();
    end
    tx_ready = 1'b1;
    drive(1'b1, CONS, 32'h38);
    step();
    tx_ready = 1'b0;
    drive(1'b0, CONS, 32'd0);
    check("push_pop_full_no_overflow", rd, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_after_pushpop", {24'b0, tx_data}, 32'h31 + 32'(i));
      step();
    end
    tx_ready = 1'b0;
    drive(1'b0, CONS, 32'd0);
    check("status_empty_again", rd, 32'h2);

    // Counter keeps counting; writes to it are ignored
    drive(1'b1, CYC, 32'd0);
    step();
    drive(1'b0, CYC, 32'd0);
    check("cycle_write_ignored", rd, 32'(tbCycle));

    // Exit register: first write wins
    drive(1'b1, EXITA, 32'd0);
    check("done_before_write", {31'b0, done}, 32'd0);
    step();
    drive(1'b1, EXITA, 32'd7);
    check("done_after_first", {31'b0, done}, 32'd1);
    check("exit_code_first", exit_code, 32'd0);
    step();
    drive(1'b0, EXITA, 32'd0);
    check("exit_code_held", exit_code, 32'd0);
    check("exit_read", rd, 32'd1);

    // Reserved register
    drive(1'b1, RSV, 32'd5);
    step();
    drive(1'b0, RSV, 32'd0);
    check("reserved_read", rd, 32'd0);
    check("reserved_not_bad", {31'b0, bad_access}, 32'd0);

    // Unmapped accesses
    drive(1'b0, 32'h0000_1000, 32'd0);
    check("unmapped_past_ram_read", rd, 32'd0);
    drive(1'b0, 32'h8000_0000, 32'd0);
    check("unmapped_read", rd, 32'd0);
    check("unmapped_read_no_flag", {31'b0, bad_access}, 32'd0);
    drive(1'b1, 32'h8000_0000, 32'h1234);
    step();
    drive(1'b0, 32'h0, 32'd0);
    check("unmapped_write_flag", {31'b0, bad_access}, 32'd1);

    // Reset with bytes queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CONS, 32'h41 + 32'(i));
      step();
    end
    drive(1'b0, CONS, 32'd0);
    check("queued_before_reset", {31'b0, tx_valid}, 32'd1);
    doReset();
    drive(1'b0, CONS, 32'd0);
    check("reset_flush_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset_bad_access", {31'b0, bad_access}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_exit_code", exit_code, 32'd0);
    check("reset_status", rd, 32'h2);
    drive(1'b0, 32'h40, 32'd0);
    check("ram_survives_reset", rd, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
